// File: rtl/rx_fifo_param.sv
// Parametrised SSP receive FIFO between the receive shifter (push) and APB read (pop).
// Ports: pclk/clear, w_en/rxdata push, psel/pwrite pop, rx_thresh watermark, ovr_clr;
// outputs prdata head, rx_level, rx_empty/rx_full, ssprxintr/ssprorintr/ssprtintr.
module rx_fifo_param #(
    parameter  int DATA_W  = 8,
    parameter  int DEPTH   = 8,
    parameter  int TIMEOUT = 32,
    localparam int LVL_W   = $clog2(DEPTH + 1)
) (
    input  logic              pclk,
    input  logic              clear,
    input  logic              w_en,
    input  logic [DATA_W-1:0] rxdata,
    input  logic              psel,
    input  logic              pwrite,
    input  logic [LVL_W-1:0]  rx_thresh,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] prdata,
    output logic [LVL_W-1:0]  rx_level,
    output logic              rx_empty,
    output logic              rx_full,
    output logic              ssprxintr,
    output logic              ssprorintr,
    output logic              ssprtintr
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              ovr;

    logic              pop;
    logic              push;
    logic              ovr_evt;
    logic [LVL_W-1:0]  thr;

    assign rx_empty = (level == '0);
    assign rx_full  = (level == LVL_W'(DEPTH));

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign pop     = psel & ~pwrite & ~rx_empty;
    assign push    = w_en & (~rx_full | pop);
    assign ovr_evt = w_en & rx_full & ~pop;

    assign thr       = (rx_thresh == '0) ? LVL_W'(1) : rx_thresh;
    assign ssprxintr = (level >= thr);
    assign ssprorintr = ovr;
    assign ssprtintr = (tmo_cnt == CNT_W'(TIMEOUT)) & ~rx_empty;
    assign rx_level  = level;
    assign prdata    = rx_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wr_ptr] <= rxdata;
        end
    end

    always_ff @(posedge pclk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Idle counter: restarts on any traffic, saturates once the timeout is reached.
    always_ff @(posedge pclk) begin
        if (clear) begin
            tmo_cnt <= '0;
        end else if (rx_empty || push || pop) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != CNT_W'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Sticky overrun; a new overrun wins over a simultaneous clear request.
    always_ff @(posedge pclk) begin
        if (clear) begin
            ovr <= 1'b0;
        end else if (ovr_evt) begin
            ovr <= 1'b1;
        end else if (ovr_clr) begin
            ovr <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rx_fifo_param.sv
// Self-checking bench for rx_fifo_param (DEPTH=8, DATA_W=8, TIMEOUT=32).
// Scoreboard queue holds pushed bytes; pops compare prdata against it.
module tb_rx_fifo_param;
    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       w_en = 1'b0;
    logic [7:0] rxdata = '0;
    logic       psel = 1'b0;
    logic       pwrite = 1'b0;
    logic [3:0] rx_thresh = 4'd4;
    logic       ovr_clr = 1'b0;
    logic [7:0] prdata;
    logic [3:0] rx_level;
    logic       rx_empty;
    logic       rx_full;
    logic       ssprxintr;
    logic       ssprorintr;
    logic       ssprtintr;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    rx_fifo_param #(.DATA_W(8), .DEPTH(8), .TIMEOUT(32)) dut (
        .pclk(clk), .clear(clear), .w_en(w_en), .rxdata(rxdata),
        .psel(psel), .pwrite(pwrite), .rx_thresh(rx_thresh),
        .ovr_clr(ovr_clr), .prdata(prdata), .rx_level(rx_level),
        .rx_empty(rx_empty), .rx_full(rx_full), .ssprxintr(ssprxintr),
        .ssprorintr(ssprorintr), .ssprtintr(ssprtintr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            rxdata = 8'(base + i);
            w_en = 1'b1;
            exp_q.push_back(8'(base + i));
            tick();
        end
        w_en = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        n_tests++;
        if (prdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_prdata: got %0h want 0", prdata);
        end
        n_tests++;
        if (rx_level !== 4'd0 || rx_empty !== 1'b1 || rx_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got lvl=%0d e=%b f=%b want 0 1 0",
                     rx_level, rx_empty, rx_full);
        end
        n_tests++;
        if ({ssprxintr, ssprorintr, ssprtintr} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_irq: got %b want 000",
                     {ssprxintr, ssprorintr, ssprtintr});
        end
    endtask

    task automatic test_fill_drain();
        rx_thresh = 4'd4;
        for (int i = 0; i < 8; i++) begin
            rxdata = 8'(i);
            w_en = 1'b1;
            exp_q.push_back(8'(i));
            tick();
            n_tests++;
            if (rx_level !== 4'(i + 1) || ssprxintr !== (i + 1 >= 4)) begin
                n_fail++;
                $display("FAIL fill_lvl_irq: got lvl=%0d rx=%b want lvl=%0d rx=%b",
                         rx_level, ssprxintr, i + 1, (i + 1 >= 4));
            end
        end
        w_en = 1'b0;
        n_tests++;
        if (rx_full !== 1'b1 || rx_level !== 4'd8) begin
            n_fail++;
            $display("FAIL fill_full: got f=%b lvl=%0d want 1 8", rx_full, rx_level);
        end
        for (int i = 0; i < 8; i++) begin
            psel = 1'b1;
            e = exp_q.pop_front();
            n_tests++;
            if (prdata !== e) begin
                n_fail++;
                $display("FAIL drain_data: got %0h want %0h", prdata, e);
            end
            tick();
        end
        psel = 1'b0;
        n_tests++;
        if (rx_empty !== 1'b1 || prdata !== 8'h00) begin
            n_fail++;
            $display("FAIL drain_empty: got e=%b d=%0h want 1 0", rx_empty, prdata);
        end
    endtask

    task automatic test_overrun();
        fill(8, 8'h00);
        rxdata = 8'hAA;
        w_en = 1'b1;
        tick();
        w_en = 1'b0;
        n_tests++;
        if (ssprorintr !== 1'b1 || rx_level !== 4'd8) begin
            n_fail++;
            $display("FAIL ovr_set: got ror=%b lvl=%0d want 1 8", ssprorintr, rx_level);
        end
        for (int i = 0; i < 8; i++) begin
            psel = 1'b1;
            e = exp_q.pop_front();
            n_tests++;
            if (prdata !== e) begin
                n_fail++;
                $display("FAIL ovr_data: got %0h want %0h", prdata, e);
            end
            tick();
        end
        psel = 1'b0;
        n_tests++;
        if (rx_empty !== 1'b1 || ssprorintr !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sticky: got e=%b ror=%b want 1 1", rx_empty, ssprorintr);
        end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        n_tests++;
        if (ssprorintr !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clr: got %b want 0", ssprorintr);
        end
    endtask

    task automatic test_push_pop_full();
        fill(8, 8'h00);
        rxdata = 8'h55;
        w_en = 1'b1;
        psel = 1'b1;
        e = exp_q.pop_front();
        n_tests++;
        if (prdata !== e) begin
            n_fail++;
            $display("FAIL pp_head: got %0h want %0h", prdata, e);
        end
        exp_q.push_back(8'h55);
        tick();
        w_en = 1'b0;
        psel = 1'b0;
        n_tests++;
        if (ssprorintr !== 1'b0 || rx_level !== 4'd8) begin
            n_fail++;
            $display("FAIL pp_full: got ror=%b lvl=%0d want 0 8", ssprorintr, rx_level);
        end
        for (int i = 0; i < 8; i++) begin
            psel = 1'b1;
            e = exp_q.pop_front();
            n_tests++;
            if (prdata !== e) begin
                n_fail++;
                $display("FAIL pp_data: got %0h want %0h", prdata, e);
            end
            tick();
        end
        psel = 1'b0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 12; i++) begin
            rxdata = 8'(8'h30 + i);
            w_en = 1'b1;
            psel = (exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (prdata !== e) begin
                    n_fail++;
                    $display("FAIL wrap_data: got %0h want %0h", prdata, e);
                end
            end
            exp_q.push_back(8'(8'h30 + i));
            tick();
        end
        w_en = 1'b0;
        psel = 1'b0;
        n_tests++;
        if (rx_level !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_lvl: got %0d want 1", rx_level);
        end
        psel = 1'b1;
        e = exp_q.pop_front();
        n_tests++;
        if (prdata !== e) begin
            n_fail++;
            $display("FAIL wrap_last: got %0h want %0h", prdata, e);
        end
        tick();
        psel = 1'b0;
    endtask

    task automatic test_thresh();
        psel = 1'b1;
        tick();
        psel = 1'b0;
        n_tests++;
        if (rx_level !== 4'd0 || rx_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL pop_empty: got lvl=%0d e=%b want 0 1", rx_level, rx_empty);
        end
        fill(1, 8'h77);
        rx_thresh = 4'd0;
        #1;
        n_tests++;
        if (ssprxintr !== 1'b1) begin
            n_fail++;
            $display("FAIL thr_zero: got %b want 1", ssprxintr);
        end
        rx_thresh = 4'd2;
        #1;
        n_tests++;
        if (ssprxintr !== 1'b0) begin
            n_fail++;
            $display("FAIL thr_live: got %b want 0", ssprxintr);
        end
        rx_thresh = 4'd4;
        psel = 1'b1;
        e = exp_q.pop_front();
        n_tests++;
        if (prdata !== e) begin
            n_fail++;
            $display("FAIL thr_data: got %0h want %0h", prdata, e);
        end
        tick();
        psel = 1'b0;
    endtask

    task automatic test_timeout();
        fill(1, 8'h11);
        for (int i = 1; i <= 32; i++) begin
            tick();
            n_tests++;
            if (ssprtintr !== (i == 32)) begin
                n_fail++;
                $display("FAIL tmo_idle%0d: got %b want %b", i, ssprtintr, (i == 32));
            end
        end
        psel = 1'b1;
        e = exp_q.pop_front();
        n_tests++;
        if (prdata !== e) begin
            n_fail++;
            $display("FAIL tmo_data: got %0h want %0h", prdata, e);
        end
        tick();
        psel = 1'b0;
        n_tests++;
        if (ssprtintr !== 1'b0 || rx_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_drop: got rt=%b e=%b want 0 1", ssprtintr, rx_empty);
        end
    endtask

    task automatic test_clear_mid();
        rx_thresh = 4'd4;
        fill(5, 8'hC0);
        n_tests++;
        if (rx_level !== 4'd5 || ssprxintr !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_pre: got lvl=%0d rx=%b want 5 1", rx_level, ssprxintr);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
        n_tests++;
        if (rx_level !== 4'd0 || prdata !== 8'h00 || rx_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_state: got lvl=%0d d=%0h e=%b want 0 0 1",
                     rx_level, prdata, rx_empty);
        end
        n_tests++;
        if ({ssprxintr, ssprorintr, ssprtintr} !== 3'b000) begin
            n_fail++;
            $display("FAIL clr_irq: got %b want 000",
                     {ssprxintr, ssprorintr, ssprtintr});
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_fill_drain();
        test_overrun();
        test_push_pop_full();
        test_wrap();
        test_thresh();
        test_timeout();
        test_clear_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
